// File: rtl/sobel_sched.sv
// +------------------------------------------------------------------------------+
// | sobel_sched: line-buffer scheduler feeding a registered 3x3 Sobel operator   |
// | Optional: SOBEL_SCHED_BORDER_PASS_EN passes the centre pixel on borders      |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module sobel_sched #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_empty,
    output logic        in_rd_en,
    input  logic [7:0]  in_dout,
    output logic [71:0] win,
    input  logic [7:0]  op_out,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [7:0]  out_din
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] kcol;
    logic [RW-1:0] krow;
    logic [7:0]    line0 [WIDTH];
    logic [7:0]    line1 [WIDTH];
    logic [23:0]   new_col;

    logic          advance, step, issue, frame_done, border_issue;
    logic          tag_valid, tag_border;
    logic          hold_valid, hold_border, hold_first;
    logic [7:0]    hold_data, border_value;

    assign advance      = !hold_valid || !out_full;
    assign border_issue = (krow == '0) || (krow == ROW_LAST) || (kcol == '0) || (kcol == COL_LAST);
    assign frame_done   = (krow == ROW_LAST) && (kcol == COL_LAST);
    assign new_col      = {in_dout, line0[col], line1[col]};

    always_ff @(posedge clock) begin
        if (reset) state <= FILL;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        step     = 1'b0;
        issue    = 1'b0;
        in_rd_en = 1'b0;
        case (state)
            FILL: if (advance && !in_empty) begin
                step     = 1'b1;
                in_rd_en = 1'b1;
                if (row == RW'(1) && col == '0) state_nx = RUN;
            end
            RUN: if (advance && !in_empty) begin
                step     = 1'b1;
                in_rd_en = 1'b1;
                issue    = 1'b1;
                if (row == ROW_LAST && col == COL_LAST) state_nx = DRAIN;
            end
            DRAIN: if (advance) begin
                step  = 1'b1;
                issue = 1'b1;
                if (frame_done) state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
        if (reset) begin
            step     = 1'b0;
            issue    = 1'b0;
            in_rd_en = 1'b0;
        end
    end

    // col keeps running through DRAIN so the window keeps shifting in step with k
    always_ff @(posedge clock) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            kcol <= '0;
            krow <= '0;
        end else if (step) begin
            if (state == DRAIN && frame_done) begin
                col  <= '0;
                row  <= '0;
                kcol <= '0;
                krow <= '0;
            end else begin
                col <= (col == COL_LAST) ? '0 : col + 1'b1;
                if (col == COL_LAST && state != DRAIN) row <= row + 1'b1;
                if (issue) begin
                    kcol <= (kcol == COL_LAST) ? '0 : kcol + 1'b1;
                    if (kcol == COL_LAST) krow <= krow + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (step) begin
            win <= {new_col[23:16], win[71:64], win[63:56],
                    new_col[15:8],  win[47:40], win[39:32],
                    new_col[7:0],   win[23:16], win[15:8]};
            line1[col] <= line0[col];
            line0[col] <= in_dout;
        end
    end

    // tag stage and holding stage advance together so op_out always matches win
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid  <= 1'b0;
            hold_valid <= 1'b0;
            hold_first <= 1'b0;
        end else if (advance) begin
            tag_valid  <= issue;
            hold_valid <= tag_valid;
            hold_first <= tag_valid;
        end else begin
            hold_first <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (advance) begin
            tag_border  <= border_issue;
            hold_border <= tag_border;
        end
        if (hold_first) hold_data <= op_out;
    end

`ifdef SOBEL_SCHED_BORDER_PASS_EN
    logic [7:0] hold_centre;

    always_ff @(posedge clock) begin
        if (advance) hold_centre <= win[39:32];
    end

    assign border_value = hold_centre;
`else
    assign border_value = 8'h00;
`endif

    assign out_wr_en = hold_valid && !out_full && !reset;
    assign out_din   = (reset || !hold_valid) ? 8'h00 :
                       hold_border ? border_value :
                       hold_first  ? op_out : hold_data;

endmodule

`default_nettype wire
